iic_slave: RTL and testbench

IIC bus slave (responder) that answers transactions from an IIC master on a shared open-drain SCL/SDA pair.
- Filters the bus lines and detects START, repeated START and STOP.
- Matches a programmable 7-bit address and ACKs it.
- Receives write bytes into a CPU-side register with a valid pulse.
- Serves read bytes through a request/ack handshake, stretching SCL while the CPU has not supplied data.
Sits beside the iic master in the iic_pro wrapper and connects to the same pads and CPU register file.

---
 rtl/iic_pkg.sv | 22 ++
 rtl/iic_in_filter.sv | 54 +++++
 rtl/iic_slave.sv | 273 +++++++++++++++++++++++++++
 tb/tb_iic_slave.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC slave: FSM state encoding and bit-slot constants.
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX_LOAD,
    ST_TX,
    ST_TX_ACK,
    ST_IDLE_WAIT
  } state_t;

  // bit_cnt value that marks the ninth (acknowledge) clock of a byte
  localparam logic [3:0] ACK_SLOT = 4'h8;

  // bit_cnt value after which the incoming byte is complete
  localparam logic [3:0] LAST_BIT = 4'h7;

endpackage

// File: rtl/iic_in_filter.sv
// Pad input conditioning: 2-flop synchronizer, FILT_LEN-sample glitch filter,
// and single-cycle rise/fall flags derived from the filtered level.
module iic_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       level_reg;
  logic       rise_reg;
  logic       fall_reg;
  logic [2:0] cnt_reg;

  // Synchronize, then flip the filtered level only after FILT_LEN disagreeing samples in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      cnt_reg   <= 3'd0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == 3'(FILT_LEN - 1)) begin
          level_reg <= sync2_reg;
          rise_reg  <= sync2_reg;
          fall_reg  <= ~sync2_reg;
          cnt_reg   <= 3'd0;
        end else begin
          cnt_reg <= cnt_reg + 3'd1;
        end
      end else begin
        cnt_reg <= 3'd0;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/iic_slave.sv
// IIC bus slave: address match, write-byte reception, read-byte service with
// CPU handshake and optional SCL stretching while waiting for tx data.
module iic_slave
  import iic_pkg::*;
#(
  parameter int FILT_LEN   = 3,
  parameter bit STRETCH_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slave_en,
  input  logic [6:0] slave_addr,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_ack,
  output logic       addr_hit,
  output logic       slave_rw,
  output logic       slave_stop,
  output logic       master_nack,
  output logic       busy
);

  // index 0 = SCL, index 1 = SDA
  logic [1:0] pad_in;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic [1:0] fall;

  assign pad_in = {sda_in, scl_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      iic_in_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk   (clk),
        .reset (reset),
        .din   (pad_in[gi]),
        .level (lvl[gi]),
        .rise  (rise[gi]),
        .fall  (fall[gi])
      );
    end
  endgenerate

  logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall;
  assign scl_f    = lvl[0];
  assign sda_f    = lvl[1];
  assign scl_rise = rise[0];
  assign scl_fall = fall[0];
  assign sda_rise = rise[1];
  assign sda_fall = fall[1];

  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_vld_reg, rx_vld_next;
  logic       tx_req_reg, tx_req_next;
  logic       tx_got_reg, tx_got_next;
  logic       addr_hit_reg, addr_hit_next;
  logic       slave_rw_reg, slave_rw_next;
  logic       slave_stop_reg, slave_stop_next;
  logic       master_nack_reg, master_nack_next;
  logic       busy_reg, busy_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       scl_oe_reg, scl_oe_next;

  logic       start_det, stop_det, tx_ack_ok;
  logic [7:0] byte_in;

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign tx_ack_ok = tx_ack & tx_req_reg;
  assign byte_in   = {shift_reg[6:0], sda_f};

  // Next-state and output decode; bus conditions override every data-phase action
  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    rx_data_next     = rx_data_reg;
    rx_vld_next      = 1'b0;
    tx_req_next      = tx_req_reg;
    tx_got_next      = tx_got_reg;
    addr_hit_next    = 1'b0;
    slave_rw_next    = slave_rw_reg;
    slave_stop_next  = 1'b0;
    master_nack_next = master_nack_reg;
    busy_next        = busy_reg;
    sda_oe_next      = sda_oe_reg;

    if (!slave_en) begin
      state_next  = ST_IDLE;
      sda_oe_next = 1'b1;
      tx_req_next = 1'b0;
      tx_got_next = 1'b0;
      busy_next   = 1'b0;
    end else if (stop_det) begin
      state_next      = ST_IDLE;
      sda_oe_next     = 1'b1;
      tx_req_next     = 1'b0;
      tx_got_next     = 1'b0;
      busy_next       = 1'b0;
      slave_stop_next = busy_reg;
    end else if (start_det) begin
      // START and repeated START both restart the address phase; busy is kept
      state_next       = ST_ADDR;
      bit_cnt_next     = 4'd0;
      sda_oe_next      = 1'b1;
      tx_req_next      = 1'b0;
      tx_got_next      = 1'b0;
      master_nack_next = 1'b0;
    end else begin
      if (tx_ack_ok) begin
        tx_req_next = 1'b0;
      end
      case (state_reg)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == LAST_BIT) begin
              if (byte_in[7:1] == slave_addr) begin
                addr_hit_next = 1'b1;
                slave_rw_next = byte_in[0];
                busy_next     = 1'b1;
                state_next    = ST_ADDR_ACK;
              end else begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_RX_ACK: begin
          // first fall: pull SDA low for the ACK clock; second fall: release and move on
          if (scl_fall) begin
            if (sda_oe_reg) begin
              sda_oe_next = 1'b0;
            end else begin
              sda_oe_next  = 1'b1;
              bit_cnt_next = 4'd0;
              if (state_reg == ST_ADDR_ACK && slave_rw_reg) begin
                state_next  = ST_TX_LOAD;
                tx_req_next = 1'b1;
                tx_got_next = 1'b0;
              end else begin
                state_next = ST_RX;
              end
            end
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == LAST_BIT) begin
              rx_data_next = byte_in;
              rx_vld_next  = 1'b1;
              state_next   = ST_RX_ACK;
            end
          end
        end
        ST_TX_LOAD: begin
          if (tx_ack_ok) begin
            shift_next  = tx_data;
            tx_got_next = 1'b1;
          end
          // the first bit may only be put on SDA while SCL is low
          if (!scl_f) begin
            if (tx_got_reg || tx_ack_ok || !STRETCH_EN) begin
              if (!tx_got_reg) begin
                shift_next = tx_data;
              end
              sda_oe_next  = tx_got_reg ? shift_reg[7] : tx_data[7];
              tx_got_next  = 1'b0;
              bit_cnt_next = 4'd0;
              state_next   = ST_TX;
            end
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == ACK_SLOT) begin
              sda_oe_next = 1'b1;
              state_next  = ST_TX_ACK;
            end else begin
              shift_next  = {shift_reg[6:0], 1'b1};
              sda_oe_next = shift_reg[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              master_nack_next = 1'b1;
              state_next       = ST_IDLE_WAIT;
            end else begin
              tx_req_next = 1'b1;
              tx_got_next = 1'b0;
              state_next  = ST_TX_LOAD;
            end
          end
        end
        default: begin
          // IDLE and IDLE_WAIT only leave on START/STOP, handled above
        end
      endcase
    end

    // Hold SCL low while waiting for tx data, plus one cycle after SDA is set up
    scl_oe_next = !(STRETCH_EN && slave_en && !scl_f &&
                    (state_next == ST_TX_LOAD ||
                     (state_reg == ST_TX_LOAD && state_next == ST_TX)));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      bit_cnt_reg     <= 4'd0;
      shift_reg       <= 8'h00;
      rx_data_reg     <= 8'h00;
      rx_vld_reg      <= 1'b0;
      tx_req_reg      <= 1'b0;
      tx_got_reg      <= 1'b0;
      addr_hit_reg    <= 1'b0;
      slave_rw_reg    <= 1'b0;
      slave_stop_reg  <= 1'b0;
      master_nack_reg <= 1'b0;
      busy_reg        <= 1'b0;
      sda_oe_reg      <= 1'b1;
      scl_oe_reg      <= 1'b1;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      rx_data_reg     <= rx_data_next;
      rx_vld_reg      <= rx_vld_next;
      tx_req_reg      <= tx_req_next;
      tx_got_reg      <= tx_got_next;
      addr_hit_reg    <= addr_hit_next;
      slave_rw_reg    <= slave_rw_next;
      slave_stop_reg  <= slave_stop_next;
      master_nack_reg <= master_nack_next;
      busy_reg        <= busy_next;
      sda_oe_reg      <= sda_oe_next;
      scl_oe_reg      <= scl_oe_next;
    end
  end

  assign scl_oe      = scl_oe_reg;
  assign sda_oe      = sda_oe_reg;
  assign sda_out     = sda_oe_reg;  // only ever drives 0; idles high
  assign rx_data     = rx_data_reg;
  assign rx_vld      = rx_vld_reg;
  assign tx_req      = tx_req_reg;
  assign addr_hit    = addr_hit_reg;
  assign slave_rw    = slave_rw_reg;
  assign slave_stop  = slave_stop_reg;
  assign master_nack = master_nack_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_iic_slave.sv
// Bench for iic_slave: bus-level master model, CPU tx responder and output monitors.
module tb_iic_slave;

  localparam int Q = 10;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       slave_en;
  logic [6:0] slave_addr;
  logic       scl_m, sda_m;
  logic       scl_in, sda_in;
  logic       scl_oe, sda_oe, sda_out;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ack;
  logic       addr_hit, slave_rw, slave_stop, master_nack, busy;

  int compared   = 0;
  int mismatched = 0;

  // monitor state
  logic [7:0] rx_q[$];
  int         hit_cnt, stop_cnt, stretch_cnt, ack_cnt;
  logic       hit_rw;
  logic       sda_drv;

  // CPU responder state
  logic [7:0] tx_bytes[$];
  int         tx_delay = 0;

  iic_slave #(.FILT_LEN(3), .STRETCH_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .slave_en    (slave_en),
    .slave_addr  (slave_addr),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .sda_out     (sda_out),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ack      (tx_ack),
    .addr_hit    (addr_hit),
    .slave_rw    (slave_rw),
    .slave_stop  (slave_stop),
    .master_nack (master_nack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // open-drain wired-AND bus
  assign scl_in = scl_m & scl_oe;
  assign sda_in = sda_m & (sda_oe | sda_out);

  always @(negedge clk) begin
    if (rx_vld === 1'b1) rx_q.push_back(rx_data);
    if (addr_hit === 1'b1) begin
      hit_cnt++;
      hit_rw = slave_rw;
    end
    if (slave_stop === 1'b1) stop_cnt++;
    if (sda_oe === 1'b0) sda_drv = 1'b1;
    if (scl_oe === 1'b0) stretch_cnt++;
    if (tx_ack === 1'b1 && tx_req === 1'b1) ack_cnt++;
  end

  initial begin
    tx_ack  = 1'b0;
    tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_req === 1'b1) begin
        repeat (tx_delay) @(negedge clk);
        tx_data = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'hFF;
        tx_ack  = 1'b1;
        @(negedge clk);
        tx_ack  = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rx_q.delete();
    hit_cnt = 0; stop_cnt = 0; stretch_cnt = 0; ack_cnt = 0;
    hit_rw = 1'b0; sda_drv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, input bit glitch, output logic rd);
    int n;
    sda_m = b;
    if (glitch) begin
      idle(Q / 2); scl_m = 1'b1; idle(1); scl_m = 1'b0; idle(Q / 2 - 1);
    end else begin
      idle(Q);
    end
    scl_m = 1'b1;
    n = 0;
    while (scl_in !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      compared++; mismatched++;
      $display("FAIL scl_release: got stretched %0d cycles expected release", n);
    end
    if (glitch) begin
      idle(H / 2); scl_m = 1'b0; idle(1); scl_m = 1'b1; idle(H / 2 - 1);
    end else begin
      idle(H);
    end
    rd = sda_in;
    scl_m = 1'b0;
    idle(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; idle(Q);
    scl_m = 1'b1; idle(H);
    sda_m = 1'b0; idle(H);
    scl_m = 1'b0; idle(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; idle(Q);
    scl_m = 1'b1; idle(H);
    sda_m = 1'b1; idle(H);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], glitch, r);
    clock_bit(1'b1, 1'b0, ack);
    $display("txn write 0x%02h ack=%0b", d, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    clock_bit(nack, 1'b0, r);
    $display("txn read 0x%02h nack=%0b", d, nack);
  endtask

  task automatic test_reset();
    logic [17:0] got;
    reset = 1'b1; slave_en = 1'b1; slave_addr = 7'h50;
    scl_m = 1'b1; sda_m = 1'b1;
    idle(4);
    got = {scl_oe, sda_oe, sda_out, rx_data, rx_vld, tx_req, addr_hit, slave_rw,
           slave_stop, master_nack, busy};
    compared++;
    if (got !== {3'b111, 15'd0}) begin
      mismatched++;
      $display("FAIL reset_values: got %05h expected %05h", got, {3'b111, 15'd0});
    end
    reset = 1'b0;
    idle(10);
    $display("txn reset done");
  endtask

  task automatic test_write_basic();
    logic a0, a1, a2;
    slave_addr = 7'h50; clear_mon();
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    compared++;
    if (hit_cnt !== 1 || hit_rw !== 1'b0) begin
      mismatched++;
      $display("FAIL wr_addr_hit: got cnt=%0d rw=%0b expected cnt=1 rw=0", hit_cnt, hit_rw);
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL wr_busy: got %0b expected 1", busy);
    end
    write_byte(8'hA5, 1'b0, a1);
    write_byte(8'h3C, 1'b0, a2);
    i2c_stop(); idle(10);
    compared++;
    if ({a0, a1, a2} !== 3'b000) begin
      mismatched++; $display("FAIL wr_acks: got %03b expected 000", {a0, a1, a2});
    end
    compared++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
      mismatched++; $display("FAIL wr_rx_data: got %p expected A5 3C", rx_q);
    end
    compared++;
    if (stop_cnt !== 1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL wr_stop: got stops=%0d busy=%0b expected 1 0", stop_cnt, busy);
    end
  endtask

  task automatic test_addr_miss();
    logic a;
    slave_addr = 7'h50; clear_mon();
    i2c_start();
    write_byte(8'hA2, 1'b0, a);
    compared++;
    if (a !== 1'b1 || sda_drv !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL miss_nack: got ack=%0b drv=%0b busy=%0b expected 1 0 0", a, sda_drv, busy);
    end
    i2c_stop(); idle(10);
    compared++;
    if (hit_cnt !== 0 || stop_cnt !== 0 || rx_q.size() != 0) begin
      mismatched++;
      $display("FAIL miss_pulses: got hit=%0d stop=%0d rx=%0d expected 0 0 0", hit_cnt, stop_cnt, rx_q.size());
    end
  endtask

  task automatic test_read_stretch();
    logic       a;
    logic [7:0] d;
    slave_addr = 7'h50; clear_mon();
    tx_bytes = {8'h96}; tx_delay = 200;
    i2c_start();
    write_byte(8'hA1, 1'b0, a);
    compared++;
    if (a !== 1'b0 || hit_rw !== 1'b1) begin
      mismatched++; $display("FAIL rd_addr: got ack=%0b rw=%0b expected 0 1", a, hit_rw);
    end
    read_byte(1'b1, d);
    compared++;
    if (d !== 8'h96) begin
      mismatched++; $display("FAIL rd_data: got %02h expected 96", d);
    end
    compared++;
    if (stretch_cnt < 198 || stretch_cnt > 210) begin
      mismatched++; $display("FAIL rd_stretch: got %0d cycles expected 198..210", stretch_cnt);
    end
    compared++;
    if (master_nack !== 1'b1 || sda_oe !== 1'b1) begin
      mismatched++;
      $display("FAIL rd_nack: got nack=%0b sda_oe=%0b expected 1 1", master_nack, sda_oe);
    end
    i2c_stop(); idle(10);
    compared++;
    if (stop_cnt !== 1 || tx_req !== 1'b0) begin
      mismatched++; $display("FAIL rd_stop: got stops=%0d req=%0b expected 1 0", stop_cnt, tx_req);
    end
    tx_delay = 0;
  endtask

  task automatic test_back_to_back();
    logic       a0, a1, a2;
    logic [7:0] exp_b[2];
    logic [7:0] d0, d1;
    slave_addr = 7'h50; clear_mon();
    exp_b[0] = 8'($urandom); exp_b[1] = 8'($urandom);
    tx_bytes = {exp_b[0], exp_b[1]}; tx_delay = 5;
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    write_byte(8'h10, 1'b0, a1);
    i2c_start();
    write_byte(8'hA1, 1'b0, a2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop(); idle(10);
    compared++;
    if ({a0, a1, a2} !== 3'b000 || hit_cnt !== 2) begin
      mismatched++; $display("FAIL rs_acks: got %03b hits=%0d expected 000 2", {a0, a1, a2}, hit_cnt);
    end
    compared++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h10) begin
      mismatched++; $display("FAIL rs_ptr: got %p expected 10", rx_q);
    end
    compared++;
    if (d0 !== exp_b[0] || d1 !== exp_b[1]) begin
      mismatched++;
      $display("FAIL rs_data: got %02h %02h expected %02h %02h", d0, d1, exp_b[0], exp_b[1]);
    end
    compared++;
    if (ack_cnt !== 2 || master_nack !== 1'b1 || stop_cnt !== 1) begin
      mismatched++;
      $display("FAIL rs_end: got acks=%0d nack=%0b stops=%0d expected 2 1 1", ack_cnt, master_nack, stop_cnt);
    end
    tx_delay = 0;
  endtask

  task automatic test_glitch_stop();
    logic       a0, a1, r;
    logic [7:0] b;
    slave_addr = 7'h50; clear_mon();
    b = 8'($urandom);
    i2c_start();
    write_byte(8'hA0, 1'b0, a0);
    write_byte(b, 1'b1, a1);
    compared++;
    if (rx_q.size() != 1 || rx_q[0] !== b || a1 !== 1'b0) begin
      mismatched++; $display("FAIL glitch_rx: got %p ack=%0b expected %02h 0", rx_q, a1, b);
    end
    // STOP after three bits of the next byte
    for (int i = 0; i < 3; i++) clock_bit(1'($urandom), 1'b0, r);
    i2c_stop(); idle(10);
    compared++;
    if (busy !== 1'b0 || tx_req !== 1'b0 || sda_oe !== 1'b1 || scl_oe !== 1'b1 || stop_cnt !== 1) begin
      mismatched++;
      $display("FAIL midbyte_stop: got busy=%0b req=%0b sda_oe=%0b scl_oe=%0b stops=%0d expected 0 0 1 1 1",
               busy, tx_req, sda_oe, scl_oe, stop_cnt);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic        a, r;
    logic [17:0] got;
    slave_addr = 7'h50; clear_mon();
    tx_bytes = {8'h00}; tx_delay = 0;
    i2c_start();
    write_byte(8'hA1, 1'b0, a);
    clock_bit(1'b1, 1'b0, r);
    clock_bit(1'b1, 1'b0, r);
    compared++;
    if (sda_oe !== 1'b0) begin
      mismatched++; $display("FAIL midtx_drive: got sda_oe=%0b expected 0", sda_oe);
    end
    reset = 1'b1;
    @(negedge clk);
    got = {scl_oe, sda_oe, sda_out, rx_data, rx_vld, tx_req, addr_hit, slave_rw,
           slave_stop, master_nack, busy};
    reset = 1'b0;
    compared++;
    if (got !== {3'b111, 15'd0}) begin
      mismatched++; $display("FAIL midtx_reset: got %05h expected %05h", got, {3'b111, 15'd0});
    end
    i2c_stop(); idle(20);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [6:0] sa, ta;
      logic       en, match, rw, a, r;
      int         n;
      logic [7:0] data[$];
      logic [7:0] d;
      clear_mon();
      sa    = 7'($urandom);
      en    = ($urandom_range(0, 5) != 0);
      match = ($urandom_range(0, 3) != 0);
      ta    = match ? sa : (sa ^ 7'($urandom_range(1, 127)));
      rw    = 1'($urandom);
      n     = $urandom_range(1, 3);
      data.delete();
      for (int k = 0; k < n; k++) data.push_back(8'($urandom));
      slave_addr = sa; slave_en = en;
      tx_delay = $urandom_range(0, 40);
      tx_bytes = data;
      idle(5);
      i2c_start();
      write_byte({ta, rw}, 1'b0, a);
      compared++;
      if (a !== !(match && en)) begin
        mismatched++; $display("FAIL rnd_addr_ack[%0d]: got %0b expected %0b", it, a, !(match && en));
      end
      if (match && en) begin
        for (int k = 0; k < n; k++) begin
          if (rw) begin
            read_byte(k == n - 1, d);
            compared++;
            if (d !== data[k]) begin
              mismatched++; $display("FAIL rnd_rd[%0d.%0d]: got %02h expected %02h", it, k, d, data[k]);
            end
          end else begin
            write_byte(data[k], 1'b0, r);
            compared++;
            if (r !== 1'b0) begin
              mismatched++; $display("FAIL rnd_wr_ack[%0d.%0d]: got %0b expected 0", it, k, r);
            end
          end
        end
      end
      i2c_stop(); idle(10);
      compared++;
      if (stop_cnt !== int'(match && en) || hit_cnt !== int'(match && en) || sda_drv !== (match && en)) begin
        mismatched++;
        $display("FAIL rnd_pulses[%0d]: got stop=%0d hit=%0d drv=%0b expected %0b", it, stop_cnt, hit_cnt, sda_drv, match && en);
      end
      compared++;
      if (!rw && match && en) begin
        if (rx_q != data) begin
          mismatched++; $display("FAIL rnd_rx[%0d]: got %p expected %p", it, rx_q, data);
        end
      end else if (rx_q.size() != 0) begin
        mismatched++; $display("FAIL rnd_rx[%0d]: got %0d bytes expected 0", it, rx_q.size());
      end
      $display("txn random %0d addr=%02h own=%02h en=%0b rw=%0b n=%0d", it, ta, sa, en, rw, n);
    end
    slave_en = 1'b1;
    tx_delay = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_addr_miss();
    test_read_stretch();
    test_back_to_back();
    test_glitch_stop();
    test_reset_mid_tx();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
